miner_msg_uart_tx: RTL
======================

# miner_msg_uart_tx

Host-side transmitter for the miner's status/result message channel. It detects each rising edge of `delivery_msg`, captures the 1024-bit `msg` word, and strips leading zero bytes. The remaining bytes go out MSB byte first on an 8N1 UART line, followed by an optional CR LF. It sits between the mining core and the board's UART pin, runs on the 50 MHz clock, and is the reader end of the `msg`/`delivery_msg` interface.

## Interface
- `CLK_HZ`, default 50_000_000: clock frequency in Hz.
- `BAUD`, default 115200: line rate.
- `MSG_BYTES`, default 128: width of `msg` in bytes. `msg` is `8*MSG_BYTES` bits.
- `APPEND_EOL`, default 1: if 1, append 0x0D 0x0A after every frame.
- `CLOCK_50`, input, 1: the single clock.
- `reset`, input, 1: synchronous, active-high reset.
- `msg`, input, 8*MSG_BYTES: message word. Content is right-aligned, with leading bytes zero.
- `delivery_msg`, input, 1: level from the mining core, asynchronous to `CLOCK_50`. A rising edge means a new message.
- `uart_tx`, output, 1: serial line. Idle high.
- `busy`, output, 1: high from edge acceptance until the last stop bit completes.
- `dropped`, output, 1: one-cycle pulse when an edge arrives while `busy`.

## Operation
- `delivery_msg` passes through a 2-flop synchronizer and a third flop for edge detection. A rising edge is the cycle when sync=1 and prev=0.
- Capture rule: on an accepted edge in IDLE, latch `msg` into `shreg` in that same cycle.
  - The producer keeps `msg` stable while `delivery_msg` is high.
  - The synchronizer delay guarantees the captured value is settled.
- States:
  - IDLE: `busy`=0. An edge latches `msg`, sets `remain`=MSG_BYTES and `busy`=1, and moves to SCAN.
  - SCAN: one byte per cycle. If the top byte of `shreg` is 0 and `remain`>0, shift `shreg` left 8 and decrement `remain`.
    - If `remain` reaches 0, the message is all zero: go to IDLE with nothing sent.
    - If the top byte is nonzero, go to START.
    - Only leading zeros are stripped. Interior zero bytes, e.g. nonce bytes, are transmitted.
  - START: drive 0 for one bit period, then go to DATA with `bitcnt`=0.
  - DATA: drive `txbyte[bitcnt]`, LSB first, for 8 bit periods. Then go to STOP.
  - STOP: drive 1 for one bit period. Then decrement `remain`.
    - If `remain`>0: shift `shreg` and go to START.
    - Else if APPEND_EOL and EOL not yet sent: send 0x0D, then 0x0A, via START/DATA/STOP.
    - Otherwise go to IDLE.
- `txbyte` selects the `shreg` top byte, or the EOL byte during the EOL phase.
- Edges seen while not IDLE are not queued. `dropped` pulses for 1 cycle and the current frame continues unaffected.
- An edge in the same cycle as STOP→IDLE is dropped (`dropped`=1).
- `reset` mid-frame forces the following on the next clock edge: IDLE, `uart_tx`=1, `busy`=0, `dropped`=0, synchronizer flops cleared. The partial byte is abandoned.
  - A `delivery_msg` that is already high after reset is not an edge until it goes low and back high.

## Timing
- Bit period DIV = round(CLK_HZ/BAUD), which is 434 at the defaults. The baud counter is ceil(log2(DIV)) bits, runs from 0 to DIV-1, and restarts at each state entry.
- Reset values: `uart_tx`=1, `busy`=0, `dropped`=0, state IDLE, all counters 0.
- From the `delivery_msg` rise to `busy`=1 is 3 clock edges.
- SCAN takes k+1 cycles, where k is the number of leading zero bytes.
- The start bit's falling edge follows the SCAN exit on the next cycle.
- Each byte takes exactly 10*DIV cycles with no inter-byte gap.
- The frame for N nonzero-led bytes lasts (N+2*APPEND_EOL)*10*DIV cycles after SCAN.
- `busy` falls in the cycle after the final stop bit's last cycle.

## Structure
- Shared package `miner_pkg` holds:
  - the state encoding (IDLE, SCAN, START, DATA, STOP);
  - frame-marker constants: `MSG_SOF`=0x5E ('^'), `MSG_PROGRESS`=0x21 ('!'), `MSG_FOUND`=0x2D ('-');
  - the EOL bytes 0x0D and 0x0A.
- One natural sub-module, `uart_tx_byte`: byte-level 8N1 serializer (start/data/stop plus baud counter) with a `valid`/`ready` handshake. The top level holds the synchronizer, capture, scan and sequencing.

## Test plan
- Use bench parameters CLK_HZ=8 and BAUD=1 (DIV=8) throughout.
- Progress frame: `msg` = {"^!!", 32'h02F79DCA, "!!"}, right-aligned, then `delivery_msg` rises.
  - Line must carry 5E 21 21 02 F7 9D CA 21 21 0D 0A, each as start, 8 LSB-first bits, stop.
  - `busy` must be high for 11*80 cycles plus SCAN.
- Interior zero: nonce 32'h00000100 in a "^--" frame. Bytes 00 00 01 00 must all be sent.
  - 9 payload bytes; SCAN lasts 120 cycles.
- All-zero `msg` edge: no start bit ever appears. `busy` returns to 0 after 128 SCAN cycles plus entry, and `uart_tx` stays 1.
- Second edge mid-frame: `delivery_msg` falls, then rises again during byte 3.
  - `dropped` must pulse exactly once.
  - The first frame must complete bit-exact, and no second frame is sent.
- Reset during the DATA bit 4 of byte 2: on the next edge `uart_tx`=1 and `busy`=0.
  - With `delivery_msg` held high, no frame follows.
  - A fresh low→high edge afterwards yields a complete frame.
- APPEND_EOL=0 with `msg` = 8'h41 in the LSB: exactly one byte 0x41 is sent, and the frame is 10*DIV cycles.

Source files
------------

// File: rtl/miner_pkg.sv
// Shared definitions for the miner message channel.
//   state_t  : bit-level serializer states (the SCAN code is kept so the whole
//              frame life-cycle shares one encoding across the codebase)
//   phase_t  : frame sequencing phases of the message transmitter
//   MSG_*    : frame-marker bytes produced by the mining core
//   EOL_*    : line terminator bytes appended after each frame
//   calc_div : rounded clock-cycles-per-bit for a given clock and baud rate
package miner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        PH_IDLE    = 3'd0,
        PH_SCAN    = 3'd1,
        PH_PAYLOAD = 3'd2,
        PH_EOL_CR  = 3'd3,
        PH_EOL_LF  = 3'd4,
        PH_DRAIN   = 3'd5
    } phase_t;

    localparam logic [7:0] MSG_SOF      = 8'h5E;  // '^'
    localparam logic [7:0] MSG_PROGRESS = 8'h21;  // '!'
    localparam logic [7:0] MSG_FOUND    = 8'h2D;  // '-'

    localparam logic [7:0] EOL_CR = 8'h0D;
    localparam logic [7:0] EOL_LF = 8'h0A;

    // Nearest-integer division so the bit period error stays below half a cycle.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Byte-level 8N1 serializer.
//   clk   : clock
//   srst  : synchronous active-high reset
//   valid : a byte is offered on data
//   data  : byte to send, LSB first
//   ready : byte accepted this cycle when valid is also high; asserted while
//           idle and in the last cycle of a stop bit so bytes chain gap-free
//   tx    : registered serial line, idle high
module uart_tx_byte
    import miner_pkg::*;
#(
    parameter int DIV = 434
)
(
    input  logic       clk,
    input  logic       srst,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx
);

    localparam int            CW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

    state_t          state_reg, state_next;
    logic [CW-1:0]   baud_cnt_reg, baud_cnt_next;
    logic [2:0]      bit_cnt_reg, bit_cnt_next;
    logic [7:0]      data_reg, data_next;
    logic            tx_reg, tx_next;
    logic            baud_last;

    assign baud_last = (baud_cnt_reg == BAUD_LAST);
    assign ready     = (state_reg == ST_IDLE) || ((state_reg == ST_STOP) && baud_last);
    assign tx        = tx_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg    <= ST_IDLE;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            data_reg     <= '0;
            tx_reg       <= 1'b1;
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            data_reg     <= data_next;
            tx_reg       <= tx_next;
        end
    end

    // tx_next is the line level of the state being entered, so the line
    // changes in the same cycle as the state register.
    always_comb begin
        state_next    = state_reg;
        baud_cnt_next = baud_cnt_reg + 1'b1;
        bit_cnt_next  = bit_cnt_reg;
        data_next     = data_reg;
        tx_next       = tx_reg;
        case (state_reg)
            ST_IDLE: begin
                baud_cnt_next = '0;
                tx_next       = 1'b1;
                if (valid) begin
                    state_next = ST_START;
                    data_next  = data;
                    tx_next    = 1'b0;
                end
            end
            ST_START: begin
                if (baud_last) begin
                    state_next    = ST_DATA;
                    baud_cnt_next = '0;
                    bit_cnt_next  = '0;
                    tx_next       = data_reg[0];
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    baud_cnt_next = '0;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = ST_STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        tx_next      = data_reg[bit_cnt_reg + 3'd1];
                    end
                end
            end
            ST_STOP: begin
                if (baud_last) begin
                    baud_cnt_next = '0;
                    if (valid) begin
                        // Next byte starts right after this stop bit: no idle gap.
                        state_next = ST_START;
                        data_next  = data;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = ST_IDLE;
                        tx_next    = 1'b1;
                    end
                end
            end
            default: begin
                state_next    = ST_IDLE;
                baud_cnt_next = '0;
                tx_next       = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/miner_msg_uart_tx.sv
// Message transmitter: captures msg on each rising edge of delivery_msg,
// strips leading zero bytes and sends the rest MSB byte first as 8N1,
// optionally followed by CR LF.
//   CLOCK_50     : clock
//   reset        : synchronous active-high reset
//   msg          : right-aligned message word, stable while delivery_msg is high
//   delivery_msg : asynchronous level, rising edge announces a new message
//   uart_tx      : serial line, idle high
//   busy         : high from edge acceptance until the last stop bit ends
//   dropped      : one-cycle pulse for an edge that arrived while busy
module miner_msg_uart_tx
    import miner_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int MSG_BYTES  = 128,
    parameter int APPEND_EOL = 1
)
(
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic [8*MSG_BYTES-1:0] msg,
    input  logic                   delivery_msg,
    output logic                   uart_tx,
    output logic                   busy,
    output logic                   dropped
);

    localparam int            DIV         = calc_div(CLK_HZ, BAUD);
    localparam int            MSG_W       = 8 * MSG_BYTES;
    localparam int            RW          = $clog2(MSG_BYTES + 1);
    localparam logic [RW-1:0] REMAIN_FULL = RW'(MSG_BYTES);

    // [0],[1] synchronize, [2] holds the previous synchronized level.
    logic [2:0]       sync_chain_reg;
    logic [1:0]       settle_reg, settle_next;
    logic             armed_reg, armed_next;
    logic             sync_level, sync_prev, rise;

    phase_t           phase_reg, phase_next;
    logic [MSG_W-1:0] shreg_reg, shreg_next;
    logic [RW-1:0]    remain_reg, remain_next;
    logic [RW-1:0]    remain_dec;
    logic             dropped_reg, dropped_next;
    logic [7:0]       top_byte;

    logic             ser_valid;
    logic [7:0]       ser_data;
    logic             ser_ready;

    assign sync_level = sync_chain_reg[1];
    assign sync_prev  = sync_chain_reg[2];
    // A level that is already high when reset ends must first be seen low
    // before it can count as an edge; armed_reg enforces that.
    assign rise       = sync_level & ~sync_prev & armed_reg;

    assign top_byte   = shreg_reg[MSG_W-1 -: 8];
    assign remain_dec = remain_reg - 1'b1;
    assign busy       = (phase_reg != PH_IDLE);
    assign dropped    = dropped_reg;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync_chain_reg <= '0;
            settle_reg     <= '0;
            armed_reg      <= 1'b0;
            phase_reg      <= PH_IDLE;
            shreg_reg      <= '0;
            remain_reg     <= '0;
            dropped_reg    <= 1'b0;
        end else begin
            sync_chain_reg <= {sync_chain_reg[1:0], delivery_msg};
            settle_reg     <= settle_next;
            armed_reg      <= armed_next;
            phase_reg      <= phase_next;
            shreg_reg      <= shreg_next;
            remain_reg     <= remain_next;
            dropped_reg    <= dropped_next;
        end
    end

    // The synchronizer holds reset values for two cycles after reset; only
    // once that has flushed does a low sync_level reflect the real input.
    always_comb begin
        settle_next = (settle_reg == 2'd2) ? settle_reg : settle_reg + 2'd1;
        armed_next  = armed_reg | ((settle_reg == 2'd2) & ~sync_level);
    end

    always_comb begin
        phase_next   = phase_reg;
        shreg_next   = shreg_reg;
        remain_next  = remain_reg;
        ser_valid    = 1'b0;
        ser_data     = top_byte;
        dropped_next = rise && (phase_reg != PH_IDLE);
        case (phase_reg)
            PH_IDLE: begin
                if (rise) begin
                    shreg_next  = msg;
                    remain_next = REMAIN_FULL;
                    phase_next  = PH_SCAN;
                end
            end
            PH_SCAN: begin
                if (remain_reg == '0) begin
                    phase_next = PH_IDLE;
                end else if (top_byte == 8'h00) begin
                    // Leading zero: discard it; an all-zero word ends here.
                    shreg_next  = {shreg_reg[MSG_W-9:0], 8'h00};
                    remain_next = remain_dec;
                    if (remain_dec == '0) begin
                        phase_next = PH_IDLE;
                    end
                end else begin
                    // First nonzero byte goes straight to the idle serializer.
                    ser_valid = 1'b1;
                    if (ser_ready) begin
                        shreg_next  = {shreg_reg[MSG_W-9:0], 8'h00};
                        remain_next = remain_dec;
                        if (remain_dec != '0) begin
                            phase_next = PH_PAYLOAD;
                        end else if (APPEND_EOL != 0) begin
                            phase_next = PH_EOL_CR;
                        end else begin
                            phase_next = PH_DRAIN;
                        end
                    end
                end
            end
            PH_PAYLOAD: begin
                // Remaining bytes, interior zeros included.
                ser_valid = 1'b1;
                if (ser_ready) begin
                    shreg_next  = {shreg_reg[MSG_W-9:0], 8'h00};
                    remain_next = remain_dec;
                    if (remain_dec != '0) begin
                        phase_next = PH_PAYLOAD;
                    end else if (APPEND_EOL != 0) begin
                        phase_next = PH_EOL_CR;
                    end else begin
                        phase_next = PH_DRAIN;
                    end
                end
            end
            PH_EOL_CR: begin
                ser_valid = 1'b1;
                ser_data  = EOL_CR;
                if (ser_ready) begin
                    phase_next = PH_EOL_LF;
                end
            end
            PH_EOL_LF: begin
                ser_valid = 1'b1;
                ser_data  = EOL_LF;
                if (ser_ready) begin
                    phase_next = PH_DRAIN;
                end
            end
            PH_DRAIN: begin
                // ready with nothing offered marks the last cycle of the final stop bit.
                if (ser_ready) begin
                    phase_next = PH_IDLE;
                end
            end
            default: begin
                phase_next = PH_IDLE;
            end
        endcase
    end

    uart_tx_byte #(
        .DIV (DIV)
    ) u_uart_tx_byte (
        .clk   (CLOCK_50),
        .srst  (reset),
        .valid (ser_valid),
        .data  (ser_data),
        .ready (ser_ready),
        .tx    (uart_tx)
    );

endmodule
